// File: rtl/rfid_pkg.sv
// Shared constants and types for the RDM6300-style RFID frame parser.
package rfid_pkg;

    localparam logic [7:0] RFID_STX         = 8'h02;
    localparam logic [7:0] RFID_ETX         = 8'h03;
    localparam int         RFID_DATA_CHARS  = 10;
    localparam int         RFID_CKSUM_CHARS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CKSUM = 2'd2,
        ST_ETX   = 2'd3
    } rfid_state_e;

    typedef enum logic [1:0] {
        BAD_HEX = 2'd0,
        CKSUM   = 2'd1,
        NO_ETX  = 2'd2,
        TIMEOUT = 2'd3
    } rfid_err_e;

endpackage

// File: rtl/ascii_hex_nibble.sv
// ASCII hex character decoder: '0'-'9', 'A'-'F', 'a'-'f' -> 4-bit value.
module ascii_hex_nibble (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       valid
);

    // Digits carry their value in the low nibble; letters A-F/a-f are low nibble + 9.
    always_comb begin
        nibble = 4'd0;
        valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = ascii[3:0];
            valid  = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            nibble = ascii[3:0] + 4'd9;
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/rfid_frame_parser.sv
// RDM6300 frame parser: STX, 10 hex data chars, 2 hex checksum chars, ETX.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for STX, all other bytes ignored
// ST_DATA  | collecting 10 hex chars, XOR-ing each completed byte
// ST_CKSUM | collecting 2 hex chars of the received checksum
// ST_ETX   | expecting ETX, then compare checksums
module rfid_frame_parser #(
    parameter int TIMEOUT_CLKS = 7020
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Tag_DV,
    output logic [39:0] o_Tag_ID,
    output logic        o_Frame_Err,
    output logic [1:0]  o_Err_Code,
    output logic        o_Busy
);
    import rfid_pkg::*;

    localparam int             TW       = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    // The timer counts idle clocks; the clock that would take it to TIMEOUT_CLKS-1 is the expiry.
    localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CLKS - 2);

    rfid_state_e   state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [39:0]   data_sr, data_n;
    logic [7:0]    run_xor, xor_n;
    logic [7:0]    rx_ck, ck_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          tag_dv, tag_dv_n;
    logic [39:0]   tag_id, id_n;
    logic          frame_err, err_n;
    rfid_err_e     err_code, code_n;

    logic [3:0]    nib;
    logic          nib_ok;

    ascii_hex_nibble u_hex (
        .ascii  (i_Rx_Byte),
        .nibble (nib),
        .valid  (nib_ok)
    );

    // State, accumulators and registered strobes.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            data_sr   <= '0;
            run_xor   <= '0;
            rx_ck     <= '0;
            tmr       <= '0;
            tag_dv    <= 1'b0;
            tag_id    <= '0;
            frame_err <= 1'b0;
            err_code  <= BAD_HEX;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            data_sr   <= data_n;
            run_xor   <= xor_n;
            rx_ck     <= ck_n;
            tmr       <= tmr_n;
            tag_dv    <= tag_dv_n;
            tag_id    <= id_n;
            frame_err <= err_n;
            err_code  <= code_n;
        end
    end

    // Next-state, accumulator updates and strobe generation.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        data_n   = data_sr;
        xor_n    = run_xor;
        ck_n     = rx_ck;
        tmr_n    = (state != ST_IDLE) ? tmr + 1'b1 : '0;
        tag_dv_n = 1'b0;
        id_n     = tag_id;
        err_n    = 1'b0;
        code_n   = err_code;

        if (i_Rx_DV) begin
            tmr_n = '0;
            if (i_Rx_Byte == RFID_STX) begin
                // A fresh STX always starts a frame; mid-frame it also aborts the old one.
                if (state != ST_IDLE) begin
                    err_n  = 1'b1;
                    code_n = NO_ETX;
                end
                state_n = ST_DATA;
                cnt_n   = '0;
                data_n  = '0;
                xor_n   = '0;
                ck_n    = '0;
            end else begin
                case (state)
                    ST_DATA: begin
                        if (nib_ok) begin
                            data_n = {data_sr[35:0], nib};
                            if (cnt[0])
                                xor_n = run_xor ^ {data_sr[3:0], nib};
                            if (cnt == 4'(RFID_DATA_CHARS - 1)) begin
                                cnt_n   = '0;
                                state_n = ST_CKSUM;
                            end else begin
                                cnt_n = cnt + 4'd1;
                            end
                        end else begin
                            err_n   = 1'b1;
                            code_n  = BAD_HEX;
                            state_n = ST_IDLE;
                        end
                    end
                    ST_CKSUM: begin
                        if (nib_ok) begin
                            ck_n = {rx_ck[3:0], nib};
                            if (cnt == 4'(RFID_CKSUM_CHARS - 1)) begin
                                cnt_n   = '0;
                                state_n = ST_ETX;
                            end else begin
                                cnt_n = cnt + 4'd1;
                            end
                        end else begin
                            err_n   = 1'b1;
                            code_n  = BAD_HEX;
                            state_n = ST_IDLE;
                        end
                    end
                    ST_ETX: begin
                        state_n = ST_IDLE;
                        if (i_Rx_Byte == RFID_ETX && rx_ck == run_xor) begin
                            tag_dv_n = 1'b1;
                            id_n     = data_sr;
                        end else begin
                            err_n  = 1'b1;
                            code_n = (i_Rx_Byte == RFID_ETX) ? CKSUM : NO_ETX;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (state != ST_IDLE && tmr == TMR_LAST) begin
            err_n   = 1'b1;
            code_n  = TIMEOUT;
            state_n = ST_IDLE;
            tmr_n   = '0;
        end
    end

    assign o_Tag_DV    = tag_dv;
    assign o_Tag_ID    = tag_id;
    assign o_Frame_Err = frame_err;
    assign o_Err_Code  = err_code;
    assign o_Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rfid_frame_parser.sv
// Directed bench for rfid_frame_parser: frame table plus timeout/reset/back-to-back sequences.
// In vector strings '<' stands for STX (0x02) and '>' for ETX (0x03).
module tb_rfid_frame_parser;

    localparam int TO = 7020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tag_dv;
    logic [39:0] tag_id;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       s;
        int          err_idx;
        int          tag_idx;
        logic [1:0]  code;
        logic [39:0] id;
    } vec_t;

    vec_t vecs[$];

    rfid_frame_parser #(.TIMEOUT_CLKS(TO)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_DV     (dv),
        .i_Rx_Byte   (rx_byte),
        .o_Tag_DV    (tag_dv),
        .o_Tag_ID    (tag_id),
        .o_Frame_Err (frame_err),
        .o_Err_Code  (err_code),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] map_ch(input byte c);
        if (c == "<") return 8'h02;
        if (c == ">") return 8'h03;
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dv      = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    // Sends a byte string; after each byte checks the strobes expected one clock later.
    task automatic run_vec(input string s, input int err_idx, input int tag_idx,
                           input logic [1:0] code, input logic [39:0] id,
                           input int gap, input logic exp_busy);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(map_ch(s[i]));
            chk($sformatf("%s[%0d] tag_dv", s, i), tag_dv, (i == tag_idx));
            chk($sformatf("%s[%0d] frame_err", s, i), frame_err, (i == err_idx));
            if (i == err_idx)
                chk($sformatf("%s[%0d] err_code", s, i), err_code, code);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                if (g == 0 && (i == err_idx || i == tag_idx)) begin
                    chk($sformatf("%s[%0d] strobe width", s, i), {tag_dv, frame_err}, 2'b00);
                    if (i == err_idx)
                        chk($sformatf("%s[%0d] err_code hold", s, i), err_code, code);
                end
            end
        end
        chk({s, " tag_id"}, tag_id, id);
        chk({s, " busy"}, busy, exp_busy);
    endtask

    task automatic add_vec(input string s, input int e, input int t,
                           input logic [1:0] c, input logic [39:0] id);
        vec_t v;
        v.s = s; v.err_idx = e; v.tag_idx = t; v.code = c; v.id = id;
        vecs.push_back(v);
    endtask

    initial begin
        logic early;

        add_vec("<0F00A1B2C3DF>",       -1, 13, 2'd0, 40'h0F00A1B2C3);
        add_vec("<0F00A1B2C3df>",       -1, 13, 2'd0, 40'h0F00A1B2C3);
        add_vec("<123456789A92>",       -1, 13, 2'd0, 40'h123456789A);
        add_vec("<0F00A1B2C3DE>",       13, -1, 2'd1, 40'h123456789A);
        add_vec("<0F0G12>",              4, -1, 2'd0, 40'h123456789A);
        add_vec("<0F00<0F00A1B2C3DF>",   5, 18, 2'd2, 40'h0F00A1B2C3);
        add_vec("<123456789A92X",       13, -1, 2'd2, 40'h0F00A1B2C3);
        add_vec("<deadbeef0123>",       -1, 13, 2'd0, 40'hDEADBEEF01);
        add_vec("<0F00A1B2C3DF>",       -1, 13, 2'd0, 40'h0F00A1B2C3);
        add_vec("Z9>A",                 -1, -1, 2'd0, 40'h0F00A1B2C3);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {tag_dv, frame_err, err_code, busy, tag_id}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Frame table.
        foreach (vecs[k])
            run_vec(vecs[k].s, vecs[k].err_idx, vecs[k].tag_idx, vecs[k].code, vecs[k].id, 2, 1'b0);

        // Timeout: STX + 2 chars then silence.
        run_vec("<0F", -1, -1, 2'd0, 40'h0F00A1B2C3, 0, 1'b1);
        early = 1'b0;
        for (int k = 1; k <= TO - 1; k++) begin
            @(posedge clk);
            #1;
            if (k < TO - 1) begin
                early = early | frame_err;
            end else begin
                chk("timeout frame_err", frame_err, 1'b1);
                chk("timeout err_code", err_code, 2'd3);
                chk("timeout busy", busy, 1'b0);
            end
        end
        chk("timeout early", early, 1'b0);
        @(posedge clk);
        #1;
        chk("timeout strobe width", frame_err, 1'b0);

        // Byte arriving on the expiry cycle wins; frame then completes.
        run_vec("<0F", -1, -1, 2'd0, 40'h0F00A1B2C3, 0, 1'b1);
        early = 1'b0;
        repeat (TO - 2) begin
            @(posedge clk);
            #1;
            early = early | frame_err;
        end
        chk("expiry pre-byte err", early, 1'b0);
        run_vec("00A1B2C3DF>", -1, 10, 2'd0, 40'h0F00A1B2C3, 1, 1'b0);

        // Back-to-back bytes, DV every cycle.
        run_vec("<deadbeef0123>", -1, 13, 2'd0, 40'hDEADBEEF01, 0, 1'b0);
        run_vec("<123456789A92>", -1, 13, 2'd0, 40'h123456789A, 0, 1'b0);

        // Reset mid-frame after 6 data chars.
        run_vec("<0F00A1", -1, -1, 2'd0, 40'h123456789A, 0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset outputs", {tag_dv, frame_err, err_code, busy, tag_id}, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("midreset no strobes", {tag_dv, frame_err}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        run_vec("B2C3DF>", -1, -1, 2'd0, 40'h0, 1, 1'b0);
        run_vec("<0F00A1B2C3DF>", -1, 13, 2'd0, 40'h0F00A1B2C3, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
